nios_ii_e: RTL and testbench
============================

NIOS_II_E -- requirements
Module: nios_ii_e

Interface
REQ-001 Parameter START_TIMEOUT, default 1048576, max clock cycles start_send_export stays high waiting for issending_export.
REQ-002 clk_clk  input  1  single system clock; all logic rising-edge.
REQ-003 reset_reset_n  input  1  asynchronous, active-low reset.
REQ-004 switches_export  input  10  [7:0] transmit byte, [8] send request, [9] unused.
REQ-005 leds_export  output  10  [7:0] last received byte, [8] transmit busy, [9] receive in progress.
REQ-006 parallel_in_export  output  8  byte presented to the serial transmitter.
REQ-007 start_send_export  output  1  transmit request to the serial transmitter.
REQ-008 issending_export  input  1  transmitter busy status, asynchronous to clk_clk.
REQ-009 isreceiving_export  input  1  receiver busy status, asynchronous to clk_clk.
REQ-010 parallel_out_export  input  8  byte from the serial receiver, valid while isreceiving_export is high.

Function
REQ-011 switches_export, issending_export, isreceiving_export and parallel_out_export SHALL each pass through a 2-flop synchronizer before use.
REQ-012 A send trigger SHALL be a 0->1 transition of synchronized switches_export[8]; level-high alone SHALL NOT retrigger.
REQ-013 Transmit FSM states: IDLE, REQ, BUSY.
REQ-014 IDLE + trigger -> REQ; switches[7:0] latched into tx register the same cycle; start_send high from the next cycle.
REQ-015 A trigger in REQ or BUSY SHALL be ignored, with tx register unchanged.
REQ-016 REQ: start_send_export = 1; synchronized issending high -> BUSY, start_send low the next cycle.
REQ-017 REQ: after START_TIMEOUT cycles without issending high -> IDLE, start_send low, no retry.
REQ-018 BUSY: synchronized issending low -> IDLE.
REQ-019 parallel_in_export SHALL always equal the tx register, held stable from latch until the next accepted trigger.
REQ-020 leds_export[8] SHALL be 1 whenever the FSM is not IDLE.
REQ-021 While synchronized isreceiving is high, synchronized parallel_out SHALL be copied into a shadow register every cycle.
REQ-022 On the 1->0 transition of synchronized isreceiving, the shadow register SHALL be committed to leds_export[7:0]; the display holds until the next commit.
REQ-023 leds_export[9] SHALL equal synchronized isreceiving.
REQ-024 The receive path SHALL be independent of the transmit FSM; simultaneous transmit and receive SHALL both complete correctly.
REQ-025 Timeout counter width SHALL be ceil(log2(START_TIMEOUT+1)); it clears on entry to REQ and does not wrap.
REQ-026 All outputs SHALL be registered; there is no combinational input-to-output path.

Reset
REQ-027 reset_reset_n low SHALL immediately force: FSM IDLE, start_send_export 0, parallel_in_export 0x00, leds_export 0x000, shadow 0x00, synchronizers 0, timeout counter 0.
REQ-028 Reset asserted in REQ or BUSY SHALL abort the transfer with start_send low at once; after release, a trigger needs a fresh 0->1 on switches[8].
REQ-029 switches_export[8] high during reset release SHALL NOT count as a trigger.

Verification
REQ-030 switches=0x0A5 then 0x1A5, issending rises 10 cycles later and falls 200 cycles later -> parallel_in=0xA5, start_send high until 1 cycle after synchronized issending rises, leds[8] high through BUSY and low afterward.
REQ-031 isreceiving high 50 cycles with parallel_out=0x3C, then low -> leds[9] high during the window, leds[7:0]=0x3C about 3 cycles after the fall.
REQ-032 START_TIMEOUT=16, trigger with issending held 0 -> start_send high exactly 16 cycles, then IDLE with leds[8]=0.
REQ-033 During BUSY, switches changed to 0x05A with a new 0->1 on bit 8 -> parallel_in stays 0xA5 and no second request is issued.
REQ-034 Reset pulsed while in REQ -> start_send 0 and leds 0x000 without waiting for a clock edge; switches[8] held high after release produces no request.
REQ-035 Transmit and receive windows overlapping -> both complete; leds[7:0] shows the received byte and parallel_in keeps the sent byte.

Source files
------------

// File: rtl/nios_ii_e_if.sv
// rtl/nios_ii_e_if.sv - switch/LED and serial transceiver signal bundle for nios_ii_e
interface nios_ii_e_if;
   logic [9:0] switches_export;
   logic [9:0] leds_export;
   logic [7:0] parallel_in_export;
   logic       start_send_export;
   logic       issending_export;
   logic       isreceiving_export;
   logic [7:0] parallel_out_export;

   // Stimulus / board side
   modport master (
      output switches_export,
      output issending_export,
      output isreceiving_export,
      output parallel_out_export,
      input  leds_export,
      input  parallel_in_export,
      input  start_send_export
   );

   // Controller side
   modport slave (
      input  switches_export,
      input  issending_export,
      input  isreceiving_export,
      input  parallel_out_export,
      output leds_export,
      output parallel_in_export,
      output start_send_export
   );
endinterface

// File: rtl/nios_ii_e.sv
// rtl/nios_ii_e.sv - switch-driven serial transmit requester and receive byte display
module nios_ii_e #(
   parameter int START_TIMEOUT = 1048576
) (
   input  logic        clk_clk,
   input  logic        reset_reset_n,
   nios_ii_e_if.slave  bus
);

   localparam int CNT_W = $clog2(START_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      BUSY = 2'd2
   } txState_t;

   txState_t         state;
   txState_t         nextState;

   logic [8:0]       swMeta;
   logic [8:0]       swSync;
   logic             sendMeta;
   logic             sendSync;
   logic             rcvMeta;
   logic             rcvSync;
   logic [7:0]       poMeta;
   logic [7:0]       poSync;

   logic [1:0]       syncFill;
   logic             armed;
   logic             trigger;

   logic [CNT_W-1:0] cnt;
   logic             cntClear;
   logic             cntInc;

   logic [7:0]       txReg;
   logic             startSendQ;
   logic             busyQ;

   logic             rcvPrev;
   logic [7:0]       shadow;
   logic [7:0]       rxByte;

   // Bit 9 of the switches has no function
   logic             unusedSw9;
   assign unusedSw9 = bus.switches_export[9];

   // Two-flop synchronizers for every input coming from outside the clock domain
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         swMeta   <= '0;
         swSync   <= '0;
         sendMeta <= 1'b0;
         sendSync <= 1'b0;
         rcvMeta  <= 1'b0;
         rcvSync  <= 1'b0;
         poMeta   <= '0;
         poSync   <= '0;
      end else begin
         swMeta   <= bus.switches_export[8:0];
         swSync   <= swMeta;
         sendMeta <= bus.issending_export;
         sendSync <= sendMeta;
         rcvMeta  <= bus.isreceiving_export;
         rcvSync  <= rcvMeta;
         poMeta   <= bus.parallel_out_export;
         poSync   <= poMeta;
      end
   end

   // Send-edge detector: armed only after seeing the request bit low once the
   // synchronizer has been refilled, so a switch held high across reset never fires
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         syncFill <= 2'b00;
         armed    <= 1'b0;
      end else begin
         syncFill <= {syncFill[0], 1'b1};
         armed    <= syncFill[1] ? ~swSync[8] : 1'b0;
      end
   end

   assign trigger = swSync[8] & armed;

   // Transmit FSM state register and request timeout counter
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= nextState;
         if (cntClear) begin
            cnt <= '0;
         end else if (cntInc) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   // Transmit FSM next-state and counter control
   always_comb begin
      nextState = state;
      cntClear  = 1'b0;
      cntInc    = 1'b0;
      case (state)
         IDLE: begin
            if (trigger) begin
               nextState = REQ;
               cntClear  = 1'b1;
            end
         end
         REQ: begin
            if (sendSync) begin
               nextState = BUSY;
            end else if (cnt >= CNT_LAST) begin
               nextState = IDLE;
            end else begin
               cntInc = 1'b1;
            end
         end
         BUSY: begin
            if (!sendSync) begin
               nextState = IDLE;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   // Registered transmit outputs; the byte is captured only on an accepted trigger
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         txReg      <= '0;
         startSendQ <= 1'b0;
         busyQ      <= 1'b0;
      end else begin
         if (state == IDLE && trigger) begin
            txReg <= swSync[7:0];
         end
         startSendQ <= (nextState == REQ);
         busyQ      <= (nextState != IDLE);
      end
   end

   // Receive path: shadow the incoming byte while receiving, commit it on the falling edge
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         rcvPrev <= 1'b0;
         shadow  <= '0;
         rxByte  <= '0;
      end else begin
         rcvPrev <= rcvSync;
         if (rcvSync) begin
            shadow <= poSync;
         end
         if (rcvPrev && !rcvSync) begin
            rxByte <= shadow;
         end
      end
   end

   assign bus.leds_export        = {rcvSync, busyQ, rxByte};
   assign bus.parallel_in_export = txReg;
   assign bus.start_send_export  = startSendQ;

endmodule

// File: tb/tb_nios_ii_e.sv
// tb/tb_nios_ii_e.sv - directed self-checking bench for nios_ii_e
module tb_nios_ii_e;

   logic clk;
   logic rstN;
   int   nAssert;
   int   nFail;

   nios_ii_e_if bus ();

   nios_ii_e #(.START_TIMEOUT(16)) dut (
      .clk_clk       (clk),
      .reset_reset_n (rstN),
      .bus           (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      rstN = 1'b0;
      bus.switches_export     = 10'h000;
      bus.issending_export    = 1'b0;
      bus.isreceiving_export  = 1'b0;
      bus.parallel_out_export = 8'h00;
      repeat (3) @(negedge clk);
      nAssert++;
      if (bus.leds_export !== 10'h000) begin
         nFail++;
         $display("FAIL reset_leds: got %h expected 000", bus.leds_export);
      end
      nAssert++;
      if (bus.parallel_in_export !== 8'h00) begin
         nFail++;
         $display("FAIL reset_parallel_in: got %h expected 00", bus.parallel_in_export);
      end
      nAssert++;
      if (bus.start_send_export !== 1'b0) begin
         nFail++;
         $display("FAIL reset_start_send: got %b expected 0", bus.start_send_export);
      end
      rstN = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_transmit();
      int cyc;
      bus.switches_export = 10'h0A5;
      repeat (4) @(negedge clk);
      bus.switches_export = 10'h1A5;
      cyc = 0;
      while (bus.start_send_export !== 1'b1 && cyc < 8) begin
         @(negedge clk);
         cyc++;
      end
      nAssert++;
      if (cyc !== 3) begin
         nFail++;
         $display("FAIL tx_request_latency: got %0d cycles expected 3", cyc);
      end
      nAssert++;
      if (bus.parallel_in_export !== 8'hA5) begin
         nFail++;
         $display("FAIL tx_parallel_in: got %h expected a5", bus.parallel_in_export);
      end
      nAssert++;
      if (bus.leds_export[8] !== 1'b1) begin
         nFail++;
         $display("FAIL tx_busy_led_req: got %b expected 1", bus.leds_export[8]);
      end
      repeat (7) @(negedge clk);
      nAssert++;
      if (bus.start_send_export !== 1'b1) begin
         nFail++;
         $display("FAIL tx_start_held: got %b expected 1", bus.start_send_export);
      end
      bus.issending_export = 1'b1;
      repeat (2) @(negedge clk);
      nAssert++;
      if (bus.start_send_export !== 1'b1) begin
         nFail++;
         $display("FAIL tx_start_until_sync: got %b expected 1", bus.start_send_export);
      end
      @(negedge clk);
      nAssert++;
      if (bus.start_send_export !== 1'b0) begin
         nFail++;
         $display("FAIL tx_start_drop: got %b expected 0", bus.start_send_export);
      end
      nAssert++;
      if (bus.leds_export[8] !== 1'b1) begin
         nFail++;
         $display("FAIL tx_busy_led_busy: got %b expected 1", bus.leds_export[8]);
      end
   endtask

   task automatic test_ignore_in_busy();
      bus.switches_export = 10'h05A;
      repeat (4) @(negedge clk);
      bus.switches_export = 10'h15A;
      repeat (6) @(negedge clk);
      nAssert++;
      if (bus.parallel_in_export !== 8'hA5) begin
         nFail++;
         $display("FAIL busy_parallel_in_hold: got %h expected a5", bus.parallel_in_export);
      end
      nAssert++;
      if (bus.start_send_export !== 1'b0) begin
         nFail++;
         $display("FAIL busy_no_request: got %b expected 0", bus.start_send_export);
      end
      repeat (187) @(negedge clk);
      bus.issending_export = 1'b0;
      repeat (2) @(negedge clk);
      nAssert++;
      if (bus.leds_export[8] !== 1'b1) begin
         nFail++;
         $display("FAIL busy_led_before_sync: got %b expected 1", bus.leds_export[8]);
      end
      @(negedge clk);
      nAssert++;
      if (bus.leds_export[8] !== 1'b0) begin
         nFail++;
         $display("FAIL busy_led_cleared: got %b expected 0", bus.leds_export[8]);
      end
      repeat (5) @(negedge clk);
      nAssert++;
      if (bus.start_send_export !== 1'b0 || bus.parallel_in_export !== 8'hA5) begin
         nFail++;
         $display("FAIL idle_no_retrigger: got start=%b byte=%h expected start=0 byte=a5",
                  bus.start_send_export, bus.parallel_in_export);
      end
   endtask

   task automatic test_receive();
      bus.parallel_out_export = 8'h3C;
      bus.isreceiving_export  = 1'b1;
      repeat (2) @(negedge clk);
      nAssert++;
      if (bus.leds_export[9] !== 1'b1) begin
         nFail++;
         $display("FAIL rx_led9_rise: got %b expected 1", bus.leds_export[9]);
      end
      repeat (48) @(negedge clk);
      nAssert++;
      if (bus.leds_export[7:0] !== 8'h00) begin
         nFail++;
         $display("FAIL rx_display_during: got %h expected 00", bus.leds_export[7:0]);
      end
      bus.isreceiving_export  = 1'b0;
      bus.parallel_out_export = 8'hFF;
      repeat (2) @(negedge clk);
      nAssert++;
      if (bus.leds_export[9] !== 1'b0 || bus.leds_export[7:0] !== 8'h00) begin
         nFail++;
         $display("FAIL rx_before_commit: got %h expected 000", bus.leds_export);
      end
      @(negedge clk);
      nAssert++;
      if (bus.leds_export[7:0] !== 8'h3C) begin
         nFail++;
         $display("FAIL rx_commit: got %h expected 3c", bus.leds_export[7:0]);
      end
      repeat (10) @(negedge clk);
      nAssert++;
      if (bus.leds_export[7:0] !== 8'h3C) begin
         nFail++;
         $display("FAIL rx_display_hold: got %h expected 3c", bus.leds_export[7:0]);
      end
   endtask

   task automatic test_timeout();
      int highCycles;
      bus.switches_export = 10'h0C3;
      repeat (4) @(negedge clk);
      bus.switches_export = 10'h1C3;
      highCycles = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.start_send_export === 1'b1) highCycles++;
      end
      nAssert++;
      if (highCycles !== 16) begin
         nFail++;
         $display("FAIL timeout_length: got %0d cycles expected 16", highCycles);
      end
      nAssert++;
      if (bus.leds_export[8] !== 1'b0 || bus.start_send_export !== 1'b0) begin
         nFail++;
         $display("FAIL timeout_idle: got busy=%b start=%b expected 0 0",
                  bus.leds_export[8], bus.start_send_export);
      end
      nAssert++;
      if (bus.parallel_in_export !== 8'hC3) begin
         nFail++;
         $display("FAIL timeout_byte: got %h expected c3", bus.parallel_in_export);
      end
   endtask

   task automatic test_reset_in_req();
      int cyc;
      int highCycles;
      bus.switches_export = 10'h012;
      repeat (4) @(negedge clk);
      bus.switches_export = 10'h112;
      cyc = 0;
      while (bus.start_send_export !== 1'b1 && cyc < 8) begin
         @(negedge clk);
         cyc++;
      end
      nAssert++;
      if (bus.start_send_export !== 1'b1) begin
         nFail++;
         $display("FAIL rstreq_enter_req: got %b expected 1", bus.start_send_export);
      end
      @(negedge clk);
      #2;
      rstN = 1'b0;
      #1;
      nAssert++;
      if (bus.start_send_export !== 1'b0) begin
         nFail++;
         $display("FAIL rstreq_async_start: got %b expected 0", bus.start_send_export);
      end
      nAssert++;
      if (bus.leds_export !== 10'h000 || bus.parallel_in_export !== 8'h00) begin
         nFail++;
         $display("FAIL rstreq_async_clear: got leds=%h byte=%h expected 000 00",
                  bus.leds_export, bus.parallel_in_export);
      end
      repeat (3) @(negedge clk);
      rstN = 1'b1;
      highCycles = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.start_send_export === 1'b1) highCycles++;
      end
      nAssert++;
      if (highCycles !== 0 || bus.leds_export[8] !== 1'b0) begin
         nFail++;
         $display("FAIL rstreq_no_trigger: got %0d request cycles busy=%b expected 0 0",
                  highCycles, bus.leds_export[8]);
      end
   endtask

   task automatic test_back_to_back();
      bus.switches_export = 10'h0E7;
      repeat (4) @(negedge clk);
      bus.switches_export     = 10'h1E7;
      bus.parallel_out_export = 8'h81;
      bus.isreceiving_export  = 1'b1;
      repeat (6) @(negedge clk);
      nAssert++;
      if (bus.start_send_export !== 1'b1 || bus.leds_export[9] !== 1'b1) begin
         nFail++;
         $display("FAIL overlap_both_active: got start=%b rx=%b expected 1 1",
                  bus.start_send_export, bus.leds_export[9]);
      end
      bus.issending_export = 1'b1;
      repeat (24) @(negedge clk);
      bus.isreceiving_export  = 1'b0;
      bus.parallel_out_export = 8'h00;
      repeat (10) @(negedge clk);
      bus.issending_export = 1'b0;
      repeat (5) @(negedge clk);
      nAssert++;
      if (bus.leds_export[7:0] !== 8'h81) begin
         nFail++;
         $display("FAIL overlap_rx_byte: got %h expected 81", bus.leds_export[7:0]);
      end
      nAssert++;
      if (bus.parallel_in_export !== 8'hE7) begin
         nFail++;
         $display("FAIL overlap_tx_byte: got %h expected e7", bus.parallel_in_export);
      end
      nAssert++;
      if (bus.leds_export[9:8] !== 2'b00 || bus.start_send_export !== 1'b0) begin
         nFail++;
         $display("FAIL overlap_idle: got leds[9:8]=%b start=%b expected 00 0",
                  bus.leds_export[9:8], bus.start_send_export);
      end
   endtask

   initial begin
      nAssert = 0;
      nFail   = 0;
      test_reset();
      test_transmit();
      test_ignore_in_busy();
      test_receive();
      test_timeout();
      test_reset_in_req();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end

endmodule
